alu_sequencer: RTL and testbench

- Multi-cycle controller that owns the shared 8-bit ALU and runs one 16-bit operation per request: add, subtract, AND, OR, signed less-than and, optionally, multiply.
- It sits between the keypad/operand front-end (start/op/operands) and the 8-bit alu instance, replacing ad-hoc byte sequencing in the top level.
- Results and flags feed the display, the LEDs and the music trigger.

---
 rtl/alu_sequencer_pkg.sv | 43 ++++
 rtl/alu_seq_opmux.sv | 55 +++++
 rtl/alu_sequencer.sv | 207 ++++++++++++++++++++
 tb/tb_alu_sequencer.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_sequencer_pkg.sv
// Shared definitions for the 16-bit ALU sequencer: ALU op-codes, FSM state
// encodings, byte/word widths and a small op classification helper.
// Optional multiply support is controlled by the CALC_MUL_EN macro in the
// files that import this package.
package alu_sequencer_pkg;

  // Width of the shared ALU data path and of one sequenced operation
  localparam int BYTE_W = 8;
  localparam int CALC_W = 2 * BYTE_W;

  // ALU op-code width and encodings
  localparam int AC_N = 3;
  localparam logic [AC_N-1:0] AC_AD = 3'd0;
  localparam logic [AC_N-1:0] AC_SB = 3'd1;
  localparam logic [AC_N-1:0] AC_AN = 3'd2;
  localparam logic [AC_N-1:0] AC_OR = 3'd3;
  localparam logic [AC_N-1:0] AC_LS = 3'd4;
  localparam logic [AC_N-1:0] AC_MU = 3'd5;

  // Sequencer states
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_CALL = 3'd1,
    S_CALH = 3'd2,
    S_MTST = 3'd3,
    S_MSH  = 3'd4
  } state_t;

  // Ops that run as a plain low-byte / high-byte pass pair (AD, SB, AN, OR, LS)
  function automatic logic op_is_two_pass(input logic [AC_N-1:0] op);
    return (op <= AC_LS);
  endfunction

  // Op-code presented to the ALU for a latched request op
  function automatic logic [AC_N-1:0] alu_code_for(input logic [AC_N-1:0] op);
    logic [AC_N-1:0] code;
    code = op;
    if (op == AC_LS) code = AC_SB;   // signed compare is a subtraction
    if (op == AC_MU) code = AC_AD;   // multiply accumulates with adds
    return code;
  endfunction

endpackage

// File: rtl/alu_seq_opmux.sv
// Combinational ALU drive selection for the ALU sequencer. Picks the ALU
// op-code, the two operand bytes and the carry-in from the current state and
// the latched operands. Outside the two ALU passes the ALU sees a quiet,
// fully defined AND of zeros. The accumulator input is only meaningful when
// CALC_MUL_EN is defined; otherwise the parent ties it to zero.
module alu_seq_opmux
  import alu_sequencer_pkg::*;
#(
  parameter int W = CALC_W
) (
  input  state_t              i_state,
  input  logic [AC_N-1:0]     i_op,
  input  logic [W-1:0]        i_ra,
  input  logic [W-1:0]        i_rb,
  input  logic [W-1:0]        i_acc,
  input  logic                i_lowcarry,
  output logic [AC_N-1:0]     o_alu_cs,
  output logic [BYTE_W-1:0]   o_alu_a,
  output logic [BYTE_W-1:0]   o_alu_b,
  output logic                o_alu_cin
);

  // Multiply passes add the shifted multiplicand to the accumulator instead of rb
  logic [W-1:0] w_opnd_b;
  assign w_opnd_b = (i_op == AC_MU) ? i_acc : i_rb;

  // Select ALU drive for the low pass, the high pass, or the idle default
  always_comb begin
    o_alu_cs  = AC_AN;
    o_alu_a   = '0;
    o_alu_b   = '0;
    o_alu_cin = 1'b0;
    case (i_state)
      S_CALL: begin
        o_alu_cs  = alu_code_for(i_op);
        o_alu_a   = i_ra[BYTE_W-1:0];
        o_alu_b   = w_opnd_b[BYTE_W-1:0];
        o_alu_cin = 1'b0;
      end
      S_CALH: begin
        o_alu_cs  = alu_code_for(i_op);
        o_alu_a   = i_ra[W-1:BYTE_W];
        o_alu_b   = w_opnd_b[W-1:BYTE_W];
        o_alu_cin = i_lowcarry;
      end
      default: begin
        o_alu_cs  = AC_AN;
        o_alu_a   = '0;
        o_alu_b   = '0;
        o_alu_cin = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/alu_sequencer.sv
// Multi-cycle controller for the shared 8-bit ALU. Each accepted request
// runs one 16-bit operation (add, subtract, AND, OR, signed less-than) as a
// low-byte pass followed by a high-byte pass, then pulses o_done with the
// result and flags held until the next accept.
// Define CALC_MUL_EN to add the shift-add multiply (AC_MU) with its
// S_MTST/S_MSH states and accumulator; without it AC_MU is an illegal op.
module alu_sequencer
  import alu_sequencer_pkg::*;
#(
  parameter int W = CALC_W
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_start,
  input  logic [AC_N-1:0]     i_op,
  input  logic [W-1:0]        i_opa,
  input  logic [W-1:0]        i_opb,
  output logic                o_busy,
  output logic                o_done,
  output logic [W-1:0]        o_result,
  output logic                o_zero,
  output logic                o_carry,
  output logic                o_compare,
  output logic                o_err,
  output logic [AC_N-1:0]     o_alu_cs,
  output logic [BYTE_W-1:0]   o_alu_a,
  output logic [BYTE_W-1:0]   o_alu_b,
  output logic                o_alu_cin,
  input  logic [BYTE_W-1:0]   i_alu_s,
  input  logic                i_alu_zero,
  input  logic                i_alu_cout
);

  state_t            r_state;
  logic [W-1:0]      r_ra;
  logic [W-1:0]      r_rb;
  logic [AC_N-1:0]   r_op;
  logic [W-1:0]      r_result;
  logic              r_zero;
  logic              r_carry;
  logic              r_compare;
  logic              r_err;
  logic              r_done;
  logic              r_lowzero;
  logic              r_lowcarry;
  logic [W-1:0]      w_acc;

  // Signed A < B from the high-byte subtraction: differing signs decide
  // directly, otherwise the sign of the difference does.
  logic              w_lt;
  assign w_lt = (r_ra[W-1] ^ r_rb[W-1]) ? r_ra[W-1] : i_alu_s[BYTE_W-1];

  // Carry out of the high pass only matters for arithmetic ops
  logic              w_arith;
  assign w_arith = (r_op == AC_AD) || (r_op == AC_SB);

`ifdef CALC_MUL_EN
  logic [W-1:0]      r_acc;
  assign w_acc = r_acc;

  // A set bit leaving ra while multiplier bits remain means the product overflows
  logic              w_shift_ovf;
  assign w_shift_ovf = r_ra[W-1] & (r_rb[W-1:1] != '0);
`else
  assign w_acc = '0;
`endif

  // Sequencer FSM with registered result, flags and done pulse
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state    <= S_IDLE;
      r_ra       <= '0;
      r_rb       <= '0;
      r_op       <= AC_AN;
      r_result   <= '0;
      r_zero     <= 1'b0;
      r_carry    <= 1'b0;
      r_compare  <= 1'b0;
      r_err      <= 1'b0;
      r_done     <= 1'b0;
      r_lowzero  <= 1'b0;
      r_lowcarry <= 1'b0;
`ifdef CALC_MUL_EN
      r_acc      <= '0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_ra      <= i_opa;
            r_rb      <= i_opb;
            r_op      <= i_op;
            r_zero    <= 1'b0;
            r_carry   <= 1'b0;
            r_compare <= 1'b0;
            r_err     <= 1'b0;
            if (op_is_two_pass(i_op)) begin
              r_state <= S_CALL;
`ifdef CALC_MUL_EN
            end else if (i_op == AC_MU) begin
              r_acc   <= '0;
              r_state <= S_MTST;
`endif
            end else begin
              // Unsupported op: report at once and stay idle
              r_result <= '0;
              r_err    <= 1'b1;
              r_done   <= 1'b1;
              r_state  <= S_IDLE;
            end
          end
        end

        S_CALL: begin
`ifdef CALC_MUL_EN
          if (r_op == AC_MU) begin
            r_acc[BYTE_W-1:0] <= i_alu_s;
          end else begin
            r_result[BYTE_W-1:0] <= i_alu_s;
          end
`else
          r_result[BYTE_W-1:0] <= i_alu_s;
`endif
          r_lowzero  <= i_alu_zero;
          r_lowcarry <= i_alu_cout;
          r_state    <= S_CALH;
        end

        S_CALH: begin
`ifdef CALC_MUL_EN
          if (r_op == AC_MU) begin
            r_acc[W-1:BYTE_W] <= i_alu_s;
            r_carry           <= r_carry | i_alu_cout;
            r_state           <= S_MSH;
          end else
`endif
          if (r_op == AC_LS) begin
            r_result  <= {{(W-1){1'b0}}, w_lt};
            r_compare <= w_lt;
            r_zero    <= ~w_lt;
            r_carry   <= 1'b0;
            r_done    <= 1'b1;
            r_state   <= S_IDLE;
          end else begin
            r_result[W-1:BYTE_W] <= i_alu_s;
            r_zero    <= r_lowzero & i_alu_zero;
            r_carry   <= w_arith & i_alu_cout;
            r_done    <= 1'b1;
            r_state   <= S_IDLE;
          end
        end

`ifdef CALC_MUL_EN
        S_MTST: begin
          if (r_rb == '0) begin
            r_result <= r_acc;
            r_zero   <= (r_acc == '0);
            r_done   <= 1'b1;
            r_state  <= S_IDLE;
          end else if (r_rb[0]) begin
            r_state  <= S_CALL;
          end else begin
            r_state  <= S_MSH;
          end
        end

        S_MSH: begin
          r_ra    <= {r_ra[W-2:0], 1'b0};
          r_rb    <= {1'b0, r_rb[W-1:1]};
          r_carry <= r_carry | w_shift_ovf;
          r_state <= S_MTST;
        end
`endif

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // ALU drive selection from state and latched operands
  alu_seq_opmux #(
    .W (W)
  ) u_opmux (
    .i_state    (r_state),
    .i_op       (r_op),
    .i_ra       (r_ra),
    .i_rb       (r_rb),
    .i_acc      (w_acc),
    .i_lowcarry (r_lowcarry),
    .o_alu_cs   (o_alu_cs),
    .o_alu_a    (o_alu_a),
    .o_alu_b    (o_alu_b),
    .o_alu_cin  (o_alu_cin)
  );

  assign o_busy    = (r_state != S_IDLE);
  assign o_done    = r_done;
  assign o_result  = r_result;
  assign o_zero    = r_zero;
  assign o_carry   = r_carry;
  assign o_compare = r_compare;
  assign o_err     = r_err;

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer. A behavioural 8-bit ALU closes the
// loop; expected 16-bit results come from a word-level reference model and
// are queued at request time, then popped when o_done pulses.
// Multiply expectations follow CALC_MUL_EN the same way the design does.
module tb_alu_sequencer;
  import alu_sequencer_pkg::*;

  logic        clk;
  logic        i_reset;
  logic        i_start;
  logic [2:0]  i_op;
  logic [15:0] i_opa;
  logic [15:0] i_opb;
  logic        o_busy, o_done, o_zero, o_carry, o_compare, o_err;
  logic [15:0] o_result;
  logic [2:0]  o_alu_cs;
  logic [7:0]  o_alu_a, o_alu_b;
  logic        o_alu_cin;
  logic [7:0]  alu_s;
  logic        alu_zero, alu_cout;

  typedef struct packed {
    logic [15:0] result;
    logic        zero;
    logic        carry;
    logic        compare;
    logic        err;
  } res_t;

  res_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  alu_sequencer dut (
    .i_clk      (clk),
    .i_reset    (i_reset),
    .i_start    (i_start),
    .i_op       (i_op),
    .i_opa      (i_opa),
    .i_opb      (i_opb),
    .o_busy     (o_busy),
    .o_done     (o_done),
    .o_result   (o_result),
    .o_zero     (o_zero),
    .o_carry    (o_carry),
    .o_compare  (o_compare),
    .o_err      (o_err),
    .o_alu_cs   (o_alu_cs),
    .o_alu_a    (o_alu_a),
    .o_alu_b    (o_alu_b),
    .o_alu_cin  (o_alu_cin),
    .i_alu_s    (alu_s),
    .i_alu_zero (alu_zero),
    .i_alu_cout (alu_cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural shared 8-bit ALU
  always_comb begin
    logic [8:0] t;
    t = '0;
    case (o_alu_cs)
      AC_AD: t = {1'b0, o_alu_a} + {1'b0, o_alu_b} + {8'd0, o_alu_cin};
      AC_SB: t = {1'b0, o_alu_a} - {1'b0, o_alu_b} - {8'd0, o_alu_cin};
      AC_AN: t = {1'b0, o_alu_a & o_alu_b};
      AC_OR: t = {1'b0, o_alu_a | o_alu_b};
      default: t = '0;
    endcase
    alu_s    = t[7:0];
    alu_cout = t[8];
    alu_zero = (t[7:0] == 8'd0);
  end

  // Word-level reference model of one request
  function automatic res_t model(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    res_t r;
    logic [16:0] s;
    logic [31:0] p;
    r = '0;
    s = '0;
    p = '0;
    case (op)
      AC_AD: begin s = {1'b0, a} + {1'b0, b}; r.result = s[15:0]; r.carry = s[16]; end
      AC_SB: begin r.result = a - b; r.carry = (a < b); end
      AC_AN: r.result = a & b;
      AC_OR: r.result = a | b;
      AC_LS: begin r.compare = ($signed(a) < $signed(b)); r.result = {15'd0, r.compare}; end
`ifdef CALC_MUL_EN
      AC_MU: begin p = a * b; r.result = p[15:0]; r.carry = (p[31:16] != 16'd0); end
`endif
      default: r.err = 1'b1;
    endcase
    if (!r.err) r.zero = (op == AC_LS) ? ~r.compare : (r.result == 16'd0);
    return r;
  endfunction

  function automatic int exp_latency(input logic [2:0] op);
    if (op <= AC_LS) return 3;
`ifdef CALC_MUL_EN
    if (op == AC_MU) return 0;   // data dependent, only bounded
`endif
    return 1;
  endfunction

  // Present one request for one cycle and queue its expected outcome
  task automatic issue(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    @(negedge clk);
    i_start = 1'b1; i_op = op; i_opa = a; i_opb = b;
    q.push_back(model(op, a, b));
    @(negedge clk);
    i_start = 1'b0;
  endtask

  // Wait (bounded) for o_done starting at cycle 'first' after the start cycle;
  // returns latency (-1 on timeout), observed outputs and the popped expectation
  task automatic collect(input int first, output res_t got, output res_t exp,
                         output int lat, output logic [7:0] bh);
    lat = first;
    bh  = '0;
    forever begin
      if (lat >= 1 && lat <= 8) bh[lat-1] = o_busy;
      if (o_done) break;
      if (lat >= 300) begin lat = -1; break; end
      @(negedge clk);
      lat++;
    end
    got = {o_result, o_zero, o_carry, o_compare, o_err};
    if (q.size() > 0) exp = q.pop_front();
    else exp = 'x;
  endtask

  task automatic test_reset();
    i_reset = 1'b1; i_start = 1'b0; i_op = '0; i_opa = '0; i_opb = '0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({o_result, o_zero, o_carry, o_compare, o_err, o_done, o_busy} !== 22'd0) begin
      n_bad++;
      $display("FAIL reset_outputs: got %h want 0", {o_result, o_zero, o_carry, o_compare, o_err, o_done, o_busy});
    end
    n_cmp++;
    if ({o_alu_cs, o_alu_a, o_alu_b, o_alu_cin} !== {AC_AN, 8'd0, 8'd0, 1'b0}) begin
      n_bad++;
      $display("FAIL reset_alu_drive: got %h want %h", {o_alu_cs, o_alu_a, o_alu_b, o_alu_cin}, {AC_AN, 17'd0});
    end
    i_reset = 1'b0;
    @(negedge clk);
    $display("reset: outputs idle");
  endtask

  task automatic test_add();
    res_t got, exp; int lat; logic [7:0] bh;
    issue(AC_AD, 16'h12FF, 16'h0001);
    collect(1, got, exp, lat, bh);
    $display("add 12ff+0001: result=%h z=%b c=%b lat=%0d", got.result, got.zero, got.carry, lat);
    n_cmp++;
    if (got !== exp || exp.result !== 16'h1300) begin
      n_bad++; $display("FAIL add_result: got %h want %h", got, exp);
    end
    n_cmp++;
    if (lat !== 3) begin n_bad++; $display("FAIL add_latency: got %0d want 3", lat); end
    n_cmp++;
    if (bh[2:0] !== 3'b011) begin n_bad++; $display("FAIL add_busy: got %b want 011", bh[2:0]); end
    @(negedge clk);
    n_cmp++;
    if (o_done !== 1'b0) begin n_bad++; $display("FAIL add_done_pulse: got %b want 0", o_done); end
    issue(AC_AD, 16'hFFFF, 16'h0001);
    collect(1, got, exp, lat, bh);
    $display("add ffff+0001: result=%h z=%b c=%b lat=%0d", got.result, got.zero, got.carry, lat);
    n_cmp++;
    if (got !== exp) begin n_bad++; $display("FAIL add_wrap: got %h want %h", got, exp); end
  endtask

  task automatic test_sub_logic();
    logic [2:0]  ops [6] = '{AC_SB, AC_SB, AC_AN, AC_OR, AC_OR, AC_AN};
    logic [15:0] as  [6] = '{16'h0000, 16'h1234, 16'hF0F0, 16'h0000, 16'h1200, 16'h00FF};
    logic [15:0] bs  [6] = '{16'h0001, 16'h1234, 16'h0FF0, 16'h0000, 16'h0034, 16'hFF00};
    res_t got, exp; int lat; logic [7:0] bh;
    for (int i = 0; i < 6; i++) begin
      issue(ops[i], as[i], bs[i]);
      collect(1, got, exp, lat, bh);
      $display("op%0d %h,%h: result=%h z=%b c=%b lat=%0d", ops[i], as[i], bs[i], got.result, got.zero, got.carry, lat);
      n_cmp++;
      if (got !== exp) begin n_bad++; $display("FAIL sublogic[%0d]: got %h want %h", i, got, exp); end
      n_cmp++;
      if (lat !== 3) begin n_bad++; $display("FAIL sublogic_lat[%0d]: got %0d want 3", i, lat); end
    end
  endtask

  task automatic test_less();
    logic [15:0] as [4] = '{16'h8000, 16'h0005, 16'h7FFF, 16'hFFFF};
    logic [15:0] bs [4] = '{16'h0001, 16'h0003, 16'h8000, 16'h0000};
    res_t got, exp; int lat; logic [7:0] bh;
    for (int i = 0; i < 4; i++) begin
      issue(AC_LS, as[i], bs[i]);
      collect(1, got, exp, lat, bh);
      $display("ls %h<%h: result=%h cmp=%b z=%b lat=%0d", as[i], bs[i], got.result, got.compare, got.zero, lat);
      n_cmp++;
      if (got !== exp) begin n_bad++; $display("FAIL less[%0d]: got %h want %h", i, got, exp); end
    end
  endtask

  task automatic test_mul();
    logic [15:0] as [4] = '{16'h0012, 16'h0300, 16'hFFFF, 16'h00FF};
    logic [15:0] bs [4] = '{16'h0034, 16'h0100, 16'hFFFF, 16'h0101};
    res_t got, exp; int lat; logic [7:0] bh;
    for (int i = 0; i < 4; i++) begin
      issue(AC_MU, as[i], bs[i]);
      collect(1, got, exp, lat, bh);
      $display("mu %h*%h: result=%h z=%b c=%b err=%b lat=%0d", as[i], bs[i], got.result, got.zero, got.carry, got.err, lat);
      n_cmp++;
      if (got !== exp) begin n_bad++; $display("FAIL mul[%0d]: got %h want %h", i, got, exp); end
`ifdef CALC_MUL_EN
      n_cmp++;
      if (lat < 2 || lat > 66) begin n_bad++; $display("FAIL mul_lat[%0d]: got %0d want 2..66", i, lat); end
`else
      n_cmp++;
      if (lat !== 1) begin n_bad++; $display("FAIL mul_illegal_lat[%0d]: got %0d want 1", i, lat); end
`endif
    end
  endtask

  task automatic test_illegal();
    res_t got, exp; int lat; logic [7:0] bh;
    for (int k = 6; k < 8; k++) begin
      issue(3'(k), 16'hABCD, 16'h1234);
      collect(1, got, exp, lat, bh);
      $display("illegal op%0d: result=%h err=%b lat=%0d", k, got.result, got.err, lat);
      n_cmp++;
      if (got !== exp) begin n_bad++; $display("FAIL illegal[%0d]: got %h want %h", k, got, exp); end
      n_cmp++;
      if (lat !== 1) begin n_bad++; $display("FAIL illegal_lat[%0d]: got %0d want 1", k, lat); end
    end
  endtask

  task automatic test_busy_ignore();
    res_t got, exp; int lat; logic [7:0] bh; int extra;
    @(negedge clk);
    i_start = 1'b1; i_op = AC_AD; i_opa = 16'h0001; i_opb = 16'h0001;
    q.push_back(model(AC_AD, 16'h0001, 16'h0001));
    @(negedge clk);
    i_op = AC_SB; i_opa = 16'h5555; i_opb = 16'h1111;
    @(negedge clk);
    i_op = AC_OR; i_opa = 16'hFFFF; i_opb = 16'h0000;
    @(negedge clk);
    i_start = 1'b0;
    collect(3, got, exp, lat, bh);
    $display("busy_ignore: result=%h lat=%0d", got.result, lat);
    n_cmp++;
    if (got !== exp) begin n_bad++; $display("FAIL busy_ignore_result: got %h want %h", got, exp); end
    extra = 0;
    repeat (6) begin @(negedge clk); if (o_done || o_busy) extra++; end
    n_cmp++;
    if (extra !== 0) begin n_bad++; $display("FAIL busy_ignore_extra: got %0d want 0", extra); end
  endtask

  task automatic test_reset_mid();
    res_t got, exp; int lat; logic [7:0] bh;
`ifdef CALC_MUL_EN
    issue(AC_MU, 16'hFFFF, 16'hFFFF);
    repeat (5) @(negedge clk);
`else
    issue(AC_AD, 16'h00FF, 16'h0001);
    @(negedge clk);
`endif
    i_reset = 1'b1;
    @(negedge clk);
    q.delete();
    n_cmp++;
    if ({o_result, o_zero, o_carry, o_compare, o_err, o_done, o_busy, o_alu_cs, o_alu_a, o_alu_b, o_alu_cin}
        !== {22'd0, AC_AN, 17'd0}) begin
      n_bad++;
      $display("FAIL reset_mid: got %h want %h",
               {o_result, o_zero, o_carry, o_compare, o_err, o_done, o_busy, o_alu_cs, o_alu_a, o_alu_b, o_alu_cin},
               {22'd0, AC_AN, 17'd0});
    end
    i_reset = 1'b0;
    issue(AC_AD, 16'h0F0F, 16'h00F1);
    collect(1, got, exp, lat, bh);
    $display("after reset add: result=%h lat=%0d", got.result, lat);
    n_cmp++;
    if (got !== exp || lat !== 3) begin
      n_bad++; $display("FAIL reset_mid_add: got %h/%0d want %h/3", got, lat, exp);
    end
  endtask

  task automatic test_random();
    res_t got, exp; int lat; logic [7:0] bh; int el;
    logic [2:0] op; logic [15:0] a, b;
    for (int i = 0; i < 24; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = 16'($urandom);
      b  = (op == AC_MU) ? 16'($urandom_range(0, 1023)) : 16'($urandom);
      issue(op, a, b);
      collect(1, got, exp, lat, bh);
      $display("rand op%0d %h,%h: result=%h z=%b c=%b cmp=%b err=%b lat=%0d",
               op, a, b, got.result, got.zero, got.carry, got.compare, got.err, lat);
      n_cmp++;
      if (got !== exp) begin n_bad++; $display("FAIL rand[%0d]: got %h want %h", i, got, exp); end
      el = exp_latency(op);
      n_cmp++;
      if ((el != 0 && lat !== el) || (el == 0 && (lat < 2 || lat > 66))) begin
        n_bad++; $display("FAIL rand_lat[%0d]: got %0d want %0d", i, lat, el);
      end
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub_logic();
    test_less();
    test_mul();
    test_illegal();
    test_busy_ignore();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
